divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIVIDEND_W, default 32, dividend and quotient width.
REQ-002 Parameter DIVISOR_W, default 16, divisor and remainder width; SHALL be less than or equal to DIVIDEND_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  DIVIDEND_W  unsigned dividend.
REQ-008 divisor  input  DIVISOR_W  unsigned divisor.
REQ-009 out_valid  output  1  result presented.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DIVIDEND_W  unsigned quotient.
REQ-012 remainder  output  DIVISOR_W  unsigned remainder.
REQ-013 div_by_zero  output  1  the result came from a zero divisor.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE; reset state is IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; an operand is accepted on an edge where in_valid and in_ready are both 1.
REQ-016 On accept with nonzero divisor: latch operands, clear the partial remainder and the iteration counter, and go to CALC.
REQ-017 On accept with zero divisor: go directly to DONE.
  - quotient = all ones.
  - remainder = dividend[DIVISOR_W-1:0].
  - div_by_zero = 1.
  - out_valid SHALL rise on the first edge after the accept edge.
REQ-018 CALC SHALL perform exactly one restoring-division step per cycle, MSB first.
  - Shift the next dividend bit into a (DIVISOR_W+1)-bit partial remainder.
  - Subtract the divisor if the result is non-negative.
  - Shift the comparison bit into the quotient.
REQ-019 After DIVIDEND_W CALC cycles the FSM SHALL enter DONE.
  - out_valid rises on the DIVIDEND_W-th edge after the accept edge (32 with defaults).
  - div_by_zero = 0.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-021 In DONE, out_valid SHALL be 1, and quotient, remainder and div_by_zero SHALL stay stable while out_ready is 0.
REQ-022 On an edge in DONE with out_ready = 1, the FSM SHALL return to IDLE and out_valid SHALL fall.
  - in_ready rises on that same edge.
  - Result registers keep their values until the next result is loaded.
REQ-023 in_valid asserted during CALC or DONE SHALL be ignored; no operand is latched.
REQ-024 in_ready and out_valid SHALL never both be 1.

Reset
REQ-025 reset low SHALL immediately force the following, regardless of clk:
  - state to IDLE;
  - in_ready = 1 once reset is released; out_valid = 0;
  - quotient = 0, remainder = 0, div_by_zero = 0;
  - iteration counter and partial remainder cleared.
REQ-026 Reset during CALC or DONE SHALL abandon the operation; no partial result SHALL ever appear with out_valid = 1.

Structure
REQ-027 Package divider_pkg SHALL hold the default widths, the state type (IDLE/CALC/DONE) and the iteration-counter width, clog2(DIVIDEND_W)+1.
REQ-028 A single combinational sub-module divider_step SHALL implement one restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
REQ-029 divider SHALL own the FSM, the counter, the operand and result registers, and the handshake.

Verification
REQ-030 dividend 30, divisor 5 -> quotient 6, remainder 0, div_by_zero 0, out_valid 32 cycles after accept.
REQ-031 dividend 100, divisor 7 -> quotient 14, remainder 2; next, 56/8 back-to-back -> 7 r 0, with in_ready low throughout the first operation.
REQ-032 dividend 32'hFFFFFFFF, divisor 16'hFFFF -> quotient 32'h00010001, remainder 0; dividend 0, divisor 3 -> 0 r 0.
REQ-033 dividend 1234, divisor 0 -> quotient 32'hFFFFFFFF, remainder 1234, div_by_zero 1, out_valid one cycle after accept.
REQ-034 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready 0; then out_ready 1 -> IDLE next edge.
REQ-035 reset pulsed low at CALC cycle 15 of 30/5 -> out_valid 0 and outputs 0 at once; a fresh 30/5 then returns 6 r 0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider.
//   DIVIDEND_W_DEF / DIVISOR_W_DEF : default operand widths
//   state_t                        : controller states
//   cnt_width()                    : iteration-counter width for a dividend width
//   CNT_W                          : counter width at the default dividend width
package divider_pkg;

   localparam int DIVIDEND_W_DEF = 32;
   localparam int DIVISOR_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration (purely combinational).
//   rem       : current partial remainder (DIVISOR_W+1 bits)
//   dvd_bit   : next dividend bit, MSB first
//   divisor   : divisor
//   rem_next  : partial remainder after this step
//   q_bit     : quotient bit produced by this step
module divider_step #(
   parameter int DIVISOR_W = 16
) (
   input  logic [DIVISOR_W:0]   rem,
   input  logic                 dvd_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_next,
   output logic                 q_bit
);

   // One extra bit of headroom so the shifted value never wraps before compare.
   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W+1:0] divisor_ext;

   assign shifted     = {rem, dvd_bit};
   assign divisor_ext = {2'b00, divisor};
   assign q_bit       = (shifted >= divisor_ext);
   // The restored value is always below the divisor, so it fits DIVISOR_W+1 bits.
   assign rem_next    = (DIVISOR_W+1)'(q_bit ? shifted - divisor_ext : shifted);

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider with valid/ready handshakes.
//   clk, reset (async, active-low)
//   in_valid / in_ready / dividend / divisor           : operand channel
//   out_valid / out_ready / quotient / remainder /
//   div_by_zero                                        : result channel
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready = 1
// CALC  | one restoring step per cycle (single cycle for a zero divisor)
// DONE  | result presented, out_valid = 1 until out_ready
module divider
   import divider_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CW = cnt_width(DIVIDEND_W);

   state_t                state, state_next;
   logic [DIVIDEND_W-1:0] dvd_q;    // dividend bits shift out the top, quotient bits in the bottom
   logic [DIVISOR_W-1:0]  dvs_q;
   logic [DIVISOR_W:0]    rem_q;
   logic [CW-1:0]         cnt_q;
   logic [DIVISOR_W:0]    rem_next;
   logic                  q_bit;
   logic                  dvs_zero;
   logic                  last_step;

   divider_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .rem      (rem_q),
      .dvd_bit  (dvd_q[DIVIDEND_W-1]),
      .divisor  (dvs_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   assign dvs_zero  = (dvs_q == '0);
   // A zero divisor spends one CALC cycle so out_valid rises on the first edge after accept.
   assign last_step = dvs_zero || (cnt_q == CW'(DIVIDEND_W - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = CALC;
         CALC:    if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
                  rem_q <= '0;
                  cnt_q <= '0;
               end
            end
            CALC: begin
               if (dvs_zero) begin
                  quotient    <= '1;
                  remainder   <= dvd_q[DIVISOR_W-1:0];
                  div_by_zero <= 1'b1;
               end else begin
                  rem_q <= rem_next;
                  dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
                  cnt_q <= cnt_q + 1'b1;
                  if (last_step) begin
                     quotient    <= {dvd_q[DIVIDEND_W-2:0], q_bit};
                     remainder   <= rem_next[DIVISOR_W-1:0];
                     div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
